// File: rtl/sgm_div_pkg.sv
// Shared types and constants for the SGM run-time round-up divider.
// The optional remainder output is enabled by SEQ_DIV_REMAINDER_EN.
package sgm_div_pkg;

    localparam int unsigned DIV_WIDTH = 10;

    // Step counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_restore_step #(
    parameter int unsigned WIDTH = 10
) (
    input  logic [WIDTH-1:0] r,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] b_ext;

    // Incoming r < b, so the shifted value needs exactly one extra bit.
    always_comb begin
        r_shift = {r, bit_in};
        b_ext   = {1'b0, b};
        q_bit   = (r_shift >= b_ext);
        r_next  = q_bit ? WIDTH'(r_shift - b_ext) : r_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div_round_up.sv
// Iterative ceil(dividend/divisor), one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIV_REMAINDER_EN to expose the floor remainder as an output port.
module seq_div_round_up
    import sgm_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
`ifdef SEQ_DIV_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_e       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt;
    logic             dz;

    logic [WIDTH-1:0] step_r;
    logic             step_q;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (pr),
        .bit_in (a_sh[WIDTH-1]),
        .b      (b_reg),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    // Divide-by-zero also passes through BUSY with a zero count, giving its one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_sh        <= '0;
            b_reg       <= '0;
            pr          <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            dz          <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_REMAINDER_EN
            remainder   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= dividend;
                        b_reg    <= divisor;
                        pr       <= '0;
                        q_reg    <= '0;
                        dz       <= (divisor == '0);
                        cnt      <= (divisor == '0) ? '0 : CW'(WIDTH);
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        pr    <= step_r;
                        q_reg <= {q_reg[WIDTH-2:0], step_q};
                        a_sh  <= {a_sh[WIDTH-2:0], 1'b0};
                        cnt   <= cnt - CW'(1);
                    end else begin
                        // Round-up cycle: ceil(a/b) <= a for b >= 1, so the +1 cannot wrap.
                        if (dz) begin
                            quotient    <= '1;
                            div_by_zero <= 1'b1;
`ifdef SEQ_DIV_REMAINDER_EN
                            remainder   <= a_sh;
`endif
                        end else begin
                            quotient    <= q_reg + WIDTH'(pr != '0);
                            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_REMAINDER_EN
                            remainder   <= pr;
`endif
                        end
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
